// File: rtl/mat_tile_sched.sv
// Operand store and schedule for the GEMM mat_sum stage.
// Streams one A/B element pair per cycle and emits each C element row-major.
module mat_tile_sched #(
    parameter int DATA_WIDTH    = 64,
    parameter int MATRIX_WIDTH  = 4,
    parameter int MATRIX_HEIGHT = 4,
    parameter int MATRIX_ADJUST = 4,
    localparam int MK = MATRIX_HEIGHT * MATRIX_ADJUST,
    localparam int KN = MATRIX_ADJUST * MATRIX_WIDTH,
    localparam int AW = $clog2((MK > KN) ? MK : KN)
) (
    input  logic                             iclk,
    input  logic                             irst,
    input  logic                             iwr_en,
    input  logic                             iwr_sel,
    input  logic [AW-1:0]                    iwr_addr,
    input  logic [DATA_WIDTH-1:0]            iwr_data,
    input  logic                             istart,
    input  logic [DATA_WIDTH-1:0]            isum,
    output logic [DATA_WIDTH-1:0]            oa_tile,
    output logic [DATA_WIDTH-1:0]            ob_tile,
    output logic [DATA_WIDTH-1:0]            ocurr_sum,
    output logic                             ores_valid,
    input  logic                             ires_ready,
    output logic [DATA_WIDTH-1:0]            ores_data,
    output logic [$clog2(MATRIX_HEIGHT)-1:0] ores_row,
    output logic [$clog2(MATRIX_WIDTH)-1:0]  ores_col,
    output logic                             obusy,
    output logic                             odone
);

    localparam int RW = $clog2(MATRIX_HEIGHT);
    localparam int CW = $clog2(MATRIX_WIDTH);
    localparam int KW = (MATRIX_ADJUST > 1) ? $clog2(MATRIX_ADJUST) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_CAPTURE,
        S_OUT,
        S_DONE
    } state_t;

    state_t state, state_d;

    logic [RW-1:0] row, row_d;
    logic [CW-1:0] col, col_d;
    logic [KW-1:0] kk, kk_d;
    logic          capture;

    logic [DATA_WIDTH-1:0] a_mem [MK];
    logic [DATA_WIDTH-1:0] b_mem [KN];

    logic          a_we, b_we;
    logic [AW-1:0] a_idx, b_idx;
    logic          last_k, last_elem;

    // Loading is only allowed while no computation is reading the buffers.
    assign a_we = (state == S_IDLE) && iwr_en && !iwr_sel &&
                  (int'(iwr_addr) < MK);
    assign b_we = (state == S_IDLE) && iwr_en && iwr_sel &&
                  (int'(iwr_addr) < KN);

    always_ff @(posedge iclk) begin
        if (irst) begin
            for (int n = 0; n < MK; n++) a_mem[n] <= '0;
        end else if (a_we) begin
            a_mem[iwr_addr] <= iwr_data;
        end
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            for (int n = 0; n < KN; n++) b_mem[n] <= '0;
        end else if (b_we) begin
            b_mem[iwr_addr] <= iwr_data;
        end
    end

    assign a_idx = AW'(row) * AW'(MATRIX_ADJUST) + AW'(kk);
    assign b_idx = AW'(kk) * AW'(MATRIX_WIDTH) + AW'(col);

    assign last_k    = (kk == KW'(MATRIX_ADJUST - 1));
    assign last_elem = (row == RW'(MATRIX_HEIGHT - 1)) &&
                       (col == CW'(MATRIX_WIDTH - 1));

    always_ff @(posedge iclk) begin
        if (irst) begin
            state     <= S_IDLE;
            row       <= '0;
            col       <= '0;
            kk        <= '0;
            ores_data <= '0;
            ores_row  <= '0;
            ores_col  <= '0;
        end else begin
            state <= state_d;
            row   <= row_d;
            col   <= col_d;
            kk    <= kk_d;
            if (capture) begin
                ores_data <= isum;
                ores_row  <= row;
                ores_col  <= col;
            end
        end
    end

    always_comb begin
        state_d = state;
        row_d   = row;
        col_d   = col;
        kk_d    = kk;
        capture = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (istart) begin
                    state_d = S_RUN;
                    row_d   = '0;
                    col_d   = '0;
                    kk_d    = '0;
                end
            end
            S_RUN: begin
                if (last_k) begin
                    state_d = S_CAPTURE;
                end else begin
                    kk_d = kk + 1'b1;
                end
            end
            S_CAPTURE: begin
                capture = 1'b1;
                state_d = S_OUT;
            end
            S_OUT: begin
                if (ires_ready) begin
                    if (last_elem) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                        kk_d    = '0;
                        if (col == CW'(MATRIX_WIDTH - 1)) begin
                            col_d = '0;
                            row_d = row + 1'b1;
                        end else begin
                            col_d = col + 1'b1;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The first product of each dot product starts from zero, later ones
    // chain on the accumulator's registered result.
    always_comb begin
        oa_tile   = '0;
        ob_tile   = '0;
        ocurr_sum = '0;
        if (state == S_RUN) begin
            oa_tile   = a_mem[a_idx];
            ob_tile   = b_mem[b_idx];
            ocurr_sum = (kk == '0) ? '0 : isum;
        end
    end

    assign ores_valid = (state == S_OUT);
    assign obusy      = (state != S_IDLE);
    assign odone      = (state == S_DONE);

endmodule

// File: tb/tb_mat_tile_sched.sv
// Scoreboard bench for mat_tile_sched with a behavioural mat_sum stand-in.
// Expected C comes from a reference matrix multiply over bench-held operands.
module tb_mat_tile_sched;

    localparam int DW = 64;
    localparam int M  = 4;
    localparam int N  = 4;
    localparam int K  = 4;
    localparam int AW = 4;
    localparam int NONE = 100000;

    logic          iclk = 1'b0;
    logic          irst;
    logic          iwr_en;
    logic          iwr_sel;
    logic [AW-1:0] iwr_addr;
    logic [DW-1:0] iwr_data;
    logic          istart;
    logic [DW-1:0] isum;
    logic [DW-1:0] oa_tile;
    logic [DW-1:0] ob_tile;
    logic [DW-1:0] ocurr_sum;
    logic          ores_valid;
    logic          ires_ready;
    logic [DW-1:0] ores_data;
    logic [1:0]    ores_row;
    logic [1:0]    ores_col;
    logic          obusy;
    logic          odone;

    always #5 iclk = ~iclk;

    mat_tile_sched #(
        .DATA_WIDTH   (DW),
        .MATRIX_WIDTH (N),
        .MATRIX_HEIGHT(M),
        .MATRIX_ADJUST(K)
    ) dut (
        .iclk      (iclk),
        .irst      (irst),
        .iwr_en    (iwr_en),
        .iwr_sel   (iwr_sel),
        .iwr_addr  (iwr_addr),
        .iwr_data  (iwr_data),
        .istart    (istart),
        .isum      (isum),
        .oa_tile   (oa_tile),
        .ob_tile   (ob_tile),
        .ocurr_sum (ocurr_sum),
        .ores_valid(ores_valid),
        .ires_ready(ires_ready),
        .ores_data (ores_data),
        .ores_row  (ores_row),
        .ores_col  (ores_col),
        .obusy     (obusy),
        .odone     (odone)
    );

    // mat_sum: registered a*b + curr, wrapping at DW bits
    always_ff @(posedge iclk) begin
        if (irst) isum <= '0;
        else      isum <= oa_tile * ob_tile + ocurr_sum;
    end

    typedef struct packed {
        logic [1:0]    r;
        logic [1:0]    c;
        logic [DW-1:0] d;
    } res_t;

    res_t          sb[$];
    res_t          got_e;
    logic [DW-1:0] ra[M*K];
    logic [DW-1:0] rb[K*N];

    int n_cmp  = 0;
    int n_err  = 0;
    int cyc    = 0;
    int t0     = 0;
    int hs_p   = -1;
    int done_p = -1;
    int n_done = 0;

    always @(posedge iclk) cyc++;

    task automatic check(input string tag, input logic [DW-1:0] got,
                         input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge iclk) begin
        if (!irst) begin
            if (ores_valid && ires_ready) begin
                if (sb.size() == 0) begin
                    check("extra_result", 64'(sb.size()), 64'd1);
                end else begin
                    got_e = sb.pop_front();
                    check("res_data", ores_data, got_e.d);
                    check("res_row", 64'(ores_row), 64'(got_e.r));
                    check("res_col", 64'(ores_col), 64'(got_e.c));
                end
                hs_p = cyc - t0;
            end
            if (odone) begin
                done_p = cyc - t0;
                n_done++;
            end
        end
    end

    task automatic chk_idle(input string tag);
        check({tag, "_valid"}, 64'(ores_valid), 64'd0);
        check({tag, "_data"}, ores_data, 64'd0);
        check({tag, "_row"}, 64'(ores_row), 64'd0);
        check({tag, "_col"}, 64'(ores_col), 64'd0);
        check({tag, "_busy"}, 64'(obusy), 64'd0);
        check({tag, "_done"}, 64'(odone), 64'd0);
        check({tag, "_a"}, oa_tile, 64'd0);
        check({tag, "_b"}, ob_tile, 64'd0);
        check({tag, "_cs"}, ocurr_sum, 64'd0);
    endtask

    task automatic wr(input logic sel, input int addr, input logic [DW-1:0] d);
        iwr_en   = 1'b1;
        iwr_sel  = sel;
        iwr_addr = AW'(addr);
        iwr_data = d;
        @(posedge iclk);
        #1;
        iwr_en = 1'b0;
    endtask

    // Leaves the final B write pending so it coincides with istart.
    task automatic load_all();
        for (int n = 0; n < M * K; n++) wr(1'b0, n, ra[n]);
        for (int n = 0; n < K * N - 1; n++) wr(1'b1, n, rb[n]);
        iwr_en   = 1'b1;
        iwr_sel  = 1'b1;
        iwr_addr = AW'(K * N - 1);
        iwr_data = rb[K*N-1];
    endtask

    task automatic push_expected();
        logic [DW-1:0] s;
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) begin
                s = '0;
                for (int k = 0; k < K; k++) s = s + ra[i*K+k] * rb[k*N+j];
                sb.push_back({2'(i), 2'(j), s});
            end
        end
    endtask

    task automatic run(input string nm, input int exp_hs, input int exp_done,
                       input int st_lo, input int st_hi,
                       input logic [DW-1:0] held, input bit poke);
        push_expected();
        istart = 1'b1;
        t0     = cyc;
        n_done = 0;
        hs_p   = -1;
        done_p = -1;
        for (int p = 0; p <= exp_done + 3; p++) begin
            @(negedge iclk);
            if (p >= 1 && p < exp_done) check({nm, "_busy"}, 64'(obusy), 64'd1);
            if (p >= st_lo && p <= st_hi) begin
                check({nm, "_stall_valid"}, 64'(ores_valid), 64'd1);
                check({nm, "_stall_data"}, ores_data, held);
                check({nm, "_stall_a"}, oa_tile, 64'd0);
            end
            @(posedge iclk);
            #1;
            istart = 1'b0;
            iwr_en = 1'b0;
            if (poke && p + 1 == 2) begin
                iwr_en   = 1'b1;
                iwr_sel  = 1'b0;
                iwr_addr = '0;
                iwr_data = 64'd999;
                istart   = 1'b1;
            end
            ires_ready = !((p + 1) >= st_lo && (p + 1) <= st_hi);
        end
        check({nm, "_last_hs"}, 64'(hs_p), 64'(exp_hs));
        check({nm, "_done_at"}, 64'(done_p), 64'(exp_done));
        check({nm, "_done_cnt"}, 64'(n_done), 64'd1);
        check({nm, "_left"}, 64'(sb.size()), 64'd0);
        check({nm, "_idle"}, 64'(obusy), 64'd0);
        sb.delete();
    endtask

    task automatic set_ident();
        for (int n = 0; n < M * K; n++) ra[n] = (n / K == n % K) ? 64'd1 : 64'd0;
        for (int n = 0; n < K * N; n++) rb[n] = 64'(10 * (n / N) + (n % N));
    endtask

    initial begin
        irst       = 1'b1;
        iwr_en     = 1'b0;
        iwr_sel    = 1'b0;
        iwr_addr   = '0;
        iwr_data   = '0;
        istart     = 1'b0;
        ires_ready = 1'b1;
        repeat (3) @(posedge iclk);
        #1;
        irst = 1'b0;
        @(negedge iclk);
        chk_idle("reset");
        @(posedge iclk);
        #1;

        set_ident();
        load_all();
        run("ident", 96, 97, NONE, NONE, '0, 1'b0);

        for (int n = 0; n < M * K; n++) ra[n] = -64'sd3;
        for (int n = 0; n < K * N; n++) rb[n] = 64'sd5;
        load_all();
        run("neg", 96, 97, NONE, NONE, '0, 1'b0);

        set_ident();
        load_all();
        run("stall", 99, 100, 42, 44, 64'd12, 1'b0);

        for (int n = 0; n < M * K; n++) ra[n] = (n < K) ? 64'h4000_0000_0000_0000 : 64'd0;
        for (int n = 0; n < K * N; n++) rb[n] = (n % N == 0) ? 64'd2 : 64'd0;
        load_all();
        run("wrap", 96, 97, NONE, NONE, '0, 1'b0);

        set_ident();
        load_all();
        run("poke", 96, 97, NONE, NONE, '0, 1'b1);
        run("after_poke", 96, 97, NONE, NONE, '0, 1'b0);

        load_all();
        push_expected();
        istart = 1'b1;
        t0     = cyc;
        hs_p   = -1;
        @(posedge iclk);
        #1;
        istart = 1'b0;
        iwr_en = 1'b0;
        repeat (7) begin
            @(posedge iclk);
            #1;
        end
        irst = 1'b1;
        @(posedge iclk);
        #1;
        irst = 1'b0;
        @(negedge iclk);
        chk_idle("midrst");
        check("midrst_hs0", 64'(hs_p), 64'd6);
        sb.delete();
        n_done = 0;
        repeat (10) @(negedge iclk);
        check("midrst_no_done", 64'(n_done), 64'd0);
        check("midrst_no_valid", 64'(ores_valid), 64'd0);
        @(posedge iclk);
        #1;
        for (int n = 0; n < M * K; n++) ra[n] = '0;
        for (int n = 0; n < K * N; n++) rb[n] = '0;
        run("cleared", 96, 97, NONE, NONE, '0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mat_tile_sched.md
# mat_tile_sched

Upstream sequencer for the `mat_sum` multiply-accumulate stage of the GEMM datapath.
- Holds local copies of operand matrices A (MATRIX_HEIGHT x MATRIX_ADJUST) and B (MATRIX_ADJUST x MATRIX_WIDTH).
- Walks every output element C[i][j] and streams one A/B element pair per cycle into `mat_sum`.
- Feeds the accumulator's registered result back as the running sum.
- Emits each finished C element on a valid/ready result port, row-major.

## Interface
- DATA_WIDTH, 64, width of every matrix element, operand and sum (two's complement)
- MATRIX_WIDTH, 4, columns of B and C (N)
- MATRIX_HEIGHT, 4, rows of A and C (M)
- MATRIX_ADJUST, 4, inner dimension: columns of A, rows of B (K)
- AW, derived: $clog2(max(M*K, K*N)), load address width

Ports:
- iclk  in  1  clock
- irst  in  1  reset; synchronous, active-high
- iwr_en  in  1  operand write strobe
- iwr_sel  in  1  0 = write A, 1 = write B
- iwr_addr  in  AW  row-major linear element index
- iwr_data  in  DATA_WIDTH  element value
- istart  in  1  start a full C computation
- isum  in  DATA_WIDTH  `mat_sum` osum (registered, 1-cycle latency)
- oa_tile  out  DATA_WIDTH  to `mat_sum` ia_matrix_tile
- ob_tile  out  DATA_WIDTH  to `mat_sum` ib_matrix_tile
- ocurr_sum  out  DATA_WIDTH  to `mat_sum` icurr_sum
- ores_valid  out  1  result element valid
- ires_ready  in  1  downstream accepts result
- ores_data  out  DATA_WIDTH  C[i][j]
- ores_row  out  $clog2(M)  i of ores_data
- ores_col  out  $clog2(N)  j of ores_data
- obusy  out  1  high in every state except IDLE
- odone  out  1  one-cycle pulse after the last result is accepted

## Operation
Storage and start:
- Operand buffers are write-only from the port and accept writes only in IDLE.
- Writes in other states, and writes with an address >= M*K (A) or >= K*N (B), are dropped.
- istart is honoured only in IDLE and ignored while obusy.

States:
- IDLE: wait for istart -> RUN with i=j=k=0.
- RUN:
  - Drive oa_tile = A[i][k] and ob_tile = B[k][j].
  - Drive ocurr_sum = 0 when k==0, otherwise isum (the previous cycle's MAC result, combinational pass-through).
  - k increments each cycle; after k==K-1 -> CAPTURE.
- CAPTURE: isum now holds the full dot product; latch it with the current i, j into the result register -> OUT.
- OUT:
  - ores_valid high; data, row and col held stable until ires_ready.
  - On handshake: if (i,j) was the last element (M-1,N-1) -> DONE.
  - Otherwise advance j (wrap to 0 and increment i), set k=0 -> RUN.
- DONE: odone=1 for one cycle -> IDLE.

Outside RUN: oa_tile, ob_tile and ocurr_sum are 0.

Arithmetic:
- Products and sums are computed inside `mat_sum` at DATA_WIDTH, signed.
- Overflow wraps modulo 2^DATA_WIDTH; this block performs no saturation.

## Timing
Reset:
- All state returns to IDLE.
- All outputs go to 0: ores_valid, ores_data, ores_row, ores_col, obusy, odone, oa_tile, ob_tile, ocurr_sum.
- Both operand buffers clear to 0.
- `mat_sum` shares irst.
- Reset asserted mid-RUN or mid-OUT aborts the computation. No odone is produced, and no pending result is presented after reset.

Schedule (istart sampled high in IDLE at cycle 0):
- RUN occupies cycles 1..K.
- CAPTURE occurs at cycle K+1.
- ores_valid is first high at cycle K+2.

Per element:
- K+2 cycles with ires_ready held high.
- Each cycle of backpressure adds one cycle.
- The MAC is idle (zero operands) during CAPTURE and OUT.

Full matrix with ires_ready held high:
- Last handshake at cycle M*N*(K+2).
- odone at the following cycle; IDLE (obusy=0) one cycle after that.
- Defaults: handshake at 96, odone at 97.

Other rules:
- A write and istart in the same IDLE cycle: the write lands, and the computation uses the written value.
- ires_ready while ores_valid is low has no effect.

## Test plan
- A = identity, B[k][j] = 10*k+j, ires_ready held high -> 16 results in row-major order with C[i][j] = 10*i+j; odone at cycle 97.
- A all -3, B all 5 (signed) -> every C element = -60 (0xFFFF_FFFF_FFFF_FFC4); ores_row/ores_col step 0,0 -> 3,3.
- ires_ready low for 3 cycles at element (1,2) -> ores_valid and ores_data held stable; no RUN activity (oa_tile=0); sequence resumes and odone shifts to cycle 100.
- Operands A[0][k]=2^62, B[k][0]=2 -> C[0][0] = 0 (wraps modulo 2^64).
- During RUN, drive iwr_en on A[0][0] and pulse istart -> both ignored; results match the pre-start operands; obusy stays high throughout.
- irst asserted at RUN cycle 2 of element (0,1) -> next cycle all outputs 0 and obusy=0; buffers read back as zero, so a new istart without reloading yields all-zero C.
